// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: M-extension opcodes and the muldiv FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement: magnitude of a signed operand, or re-signing of a result.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result_c
);

    assign result_c = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: one-bit-per-cycle shift-add multiply and restoring divide.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_value,
    output logic [4:0]      rd_out,
    output logic            regwrite
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    muldiv_state_e state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [XLEN-1:0] opb;
    logic [2:0]      op;
    logic            neg;
    logic            fast;

    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic            div_zero, div_ovf, special, accept, last, finish;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [PW-1:0]   mul_nxt, div_nxt, step_nxt, prod_fix;
    logic [XLEN-1:0] div_raw, div_fix, result;

    // Operand decode, evaluated at acceptance
    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg    = a_signed & rs1_value[XLEN-1];
    assign b_neg    = b_signed & rs2_value[XLEN-1];
    assign neg_in   = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = funct3[2] && (rs2_value == '0);
    assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (funct3[1] ? rs1_value : '1)
                                  : (funct3[1] ? '0 : rs1_value);

    muldiv_signfix #(.W(XLEN)) u_fix_a (.value(rs1_value), .negate(a_neg), .result_c(a_mag));
    muldiv_signfix #(.W(XLEN)) u_fix_b (.value(rs2_value), .negate(b_neg), .result_c(b_mag));

    // acc = {hi, lo}: product accumulator / remainder in hi, multiplier / quotient in lo
    assign mul_sum   = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {acc[PW-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_nxt   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    assign step_nxt  = op[2] ? div_nxt : mul_nxt;

    assign div_raw = op[1] ? step_nxt[PW-1:XLEN] : step_nxt[XLEN-1:0];

    muldiv_signfix #(.W(PW))   u_fix_p (.value(step_nxt), .negate(neg), .result_c(prod_fix));
    muldiv_signfix #(.W(XLEN)) u_fix_d (.value(div_raw),  .negate(neg), .result_c(div_fix));

    assign result = op[2] ? div_fix
                          : ((op == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN]);

    assign accept = start && (state != ST_CALC);
    assign last   = (state == ST_CALC) && (cnt == CW'(XLEN - 1));
    assign finish = last || ((state == ST_DONE) && fast);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = special ? ST_DONE : ST_CALC;
                else       state_nxt = ST_IDLE;
            end
            ST_CALC: if (last) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op       <= F3_MUL;
            neg      <= 1'b0;
            fast     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            regwrite <= 1'b0;
            rd_value <= '0;
            rd_out   <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == ST_CALC);
            done     <= finish;
            regwrite <= finish && (rd_out != '0);
            // Fast-path results wait in acc so a back-to-back start cannot clobber them
            if (finish) rd_value <= fast ? acc[XLEN-1:0] : result;
            if (accept) begin
                op     <= funct3;
                neg    <= neg_in;
                fast   <= special;
                rd_out <= rd_in;
                cnt    <= '0;
                acc    <= special ? {XLEN'(0), special_res} : {XLEN'(0), a_mag};
                opb    <= b_mag;
            end else if (state == ST_CALC) begin
                acc <= step_nxt;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M execute unit for the R-type core. It sits directly downstream of the register bank.
- It consumes rs1_value/rs2_value for funct7=0000001 instructions and returns rd_value/regwrite/rd to the register bank write port.
- It implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- It uses radix-2 shift-add multiply and restoring divide, one bit per cycle, with a start/busy/done handshake toward the pipeline control.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 (≥ 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when state is IDLE or DONE.
- funct3  in  3  operation select; 000 MUL … 111 REMU, per RV32M encoding.
- rs1_value  in  XLEN  operand A from register bank.
- rs2_value  in  XLEN  operand B from register bank.
- rd_in  in  5  destination register index.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse, result valid.
- rd_value  out  XLEN  result to register bank.
- rd_out  out  5  captured destination index.
- regwrite  out  1  equals done AND (rd_out != 0).

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, regwrite=0, rd_value=0, rd_out=0.
  - Counter and internal accumulators are cleared.
  - Reset mid-operation aborts the operation; no done is produced afterwards.
- States: IDLE, CALC, DONE.
- Acceptance:
  - start is accepted at edge E0 when the state is IDLE or DONE, so back-to-back issue is allowed.
  - At E0 the unit captures funct3, both operands and rd_in.
  - start while busy=1 is ignored: no capture, no effect on the operation in flight.
- Normal path:
  - E0: state goes to CALC, counter=0, busy=1.
  - Edges E0+1..E0+32: one iteration each; counter increments.
  - At E0+32: state goes to DONE and the result is registered.
  - done=1 for exactly the cycle between E0+32 and E0+33.
  - Latency is 32 cycles; busy is high for 32 cycles.
- Special-case fast path:
  - Covers DIV/DIVU/REM/REMU with divisor=0, and DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF.
  - E0: state goes directly to DONE with the result, busy stays 0.
  - done is high between E0+1 and E0+2.
- DONE state:
  - If no start: DONE goes to IDLE at the next edge and done drops.
  - rd_value and rd_out hold their values until the next accepted start.
- Multiply:
  - Signed operands are converted to magnitudes; an unsigned 64-bit product is formed.
  - The product is negated when the operand signs differ.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring divide on magnitudes.
  - The quotient is negated when the signs differ (DIV).
  - The remainder takes the sign of the dividend (REM).
- Divide by zero:
  - The quotient is all ones (0xFFFFFFFF) for both DIV and DIVU.
  - The remainder equals rs1 for both REM and REMU.
- Signed overflow (-2^31 / -1): quotient = 0x80000000, remainder = 0.
- Operand corner cases:
  - 0 as dividend, or 1 as multiplier, go through the normal path with no shortcut; latency stays 32.
  - Magnitude of 0x80000000 is 0x80000000 taken as unsigned (33rd bit not needed).

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_MUL..F3_REMU.
  - FUNCT7_MULDIV = 7'b0000001.
  - The state encoding ST_IDLE/ST_CALC/ST_DONE.
  - XLEN default.
- One sub-module, muldiv_signfix: a combinational helper shared by pre- and post-processing.
  - Inputs: value and negate flag.
  - Outputs: conditional two's-complement magnitude/negation.
- The FSM, counter and shift datapath stay in muldiv_unit.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), rd_in=5:
  - rd_value=0xFFFFFFEB.
  - done and regwrite high exactly at E0+32..E0+33.
  - busy high for 32 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD.
- REM -7%2 → 0xFFFFFFFF.
- DIVU 100/7 → 14.
- REMU 100/7 → 2.
- Each of the four divide cases takes 32 cycles.
- Special cases, each with done at E0+1 and busy never asserted:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake:
  - start pulsed again at E0+10 with different operands is ignored; the first result is returned.
  - start in the DONE cycle is accepted; the second done arrives 32 cycles later.
  - rd_in=0 gives done=1 and regwrite=0.
- Assert rst at E0+15 of a DIV:
  - All outputs are 0 immediately (asynchronous).
  - No done within 40 cycles after release.
  - A new MUL 3×4 then returns 12.
